// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types, constants and the parity helper for the UART TX path.
//           The PARITY state exists only when UART_TX_PARITY_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } tx_state_t;

  function automatic logic parity8(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// ============================================================================
// Module  : uart_sync_fifo
// Brief   : Single-clock FIFO with occupancy count; push and pop may coincide.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   c_CNT_ONE = (DEPTH_LOG2 + 1)'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  w_push;
  logic                  w_pop;

  // The count can only reach DEPTH, so its top bit alone means full.
  assign o_full  = count_q[DEPTH_LOG2];
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + c_CNT_ONE;
        2'b01:   count_q <= count_q - c_CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : FIFO-buffered 8N1/8N2 UART transmitter, back-to-back frames.
//           Define UART_TX_PARITY_EN to insert a parity bit after the data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int TICKS_PER_BIT      = 4,
  parameter int TICKS_PER_BIT_SIZE = 3,
  parameter int FIFO_DEPTH_LOG2    = 3,
  parameter int STOP_BITS          = 1,
  parameter int PARITY_ODD         = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_valid,
  input  logic [7:0]               i_wr_data,
  output logic                     o_wr_ready,
  output logic [FIFO_DEPTH_LOG2:0] o_fifo_count,
  output logic                     o_dout,
  output logic                     o_busy,
  output logic                     o_done
);

  import uart_pkg::*;

  localparam logic [FIFO_DEPTH_LOG2:0] c_DEPTH = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
  localparam logic [TICKS_PER_BIT_SIZE-1:0] c_TICK_LAST = TICKS_PER_BIT_SIZE'(TICKS_PER_BIT - 1);
  localparam logic [TICKS_PER_BIT_SIZE-1:0] c_TICK_ONE  = TICKS_PER_BIT_SIZE'(1);
  localparam logic [2:0] c_DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] c_STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_t                     state_q;
  logic [TICKS_PER_BIT_SIZE-1:0] tick_q;
  logic [2:0]                    bit_idx_q;
  logic [7:0]                    data_q;
  logic                          dout_q;
  logic                          busy_q;
  logic                          done_q;

  logic       w_empty;
  logic       w_unused_full;
  logic [7:0] w_head;
  logic       w_tick_last;
  logic       w_frame_end;
  logic       w_pop;

  assign o_wr_ready  = (o_fifo_count < c_DEPTH);
  assign o_dout      = dout_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign w_tick_last = (tick_q == c_TICK_LAST);
  assign w_frame_end = (state_q == S_STOP) && w_tick_last && (bit_idx_q == c_STOP_LAST);
  assign w_pop       = !w_empty && ((state_q == S_IDLE) || w_frame_end);

`ifndef UART_TX_PARITY_EN
  logic w_unused_parity_cfg;
  assign w_unused_parity_cfg = 1'(PARITY_ODD);
`endif

  uart_sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_wr_valid && o_wr_ready),
    .i_data  (i_wr_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_unused_full),
    .o_empty (w_empty),
    .o_count (o_fifo_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      dout_q    <= LINE_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE || w_tick_last) tick_q <= '0;
      else                                  tick_q <= tick_q + c_TICK_ONE;

      case (state_q)
        S_IDLE: begin
          if (!w_empty) begin
            data_q  <= w_head;
            dout_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (w_tick_last) begin
            bit_idx_q <= '0;
            dout_q    <= data_q[0];
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_tick_last) begin
            if (bit_idx_q == c_DATA_LAST) begin
              bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
              dout_q    <= parity8(data_q, PARITY_ODD != 0);
              state_q   <= S_PARITY;
`else
              dout_q    <= LINE_IDLE;
              state_q   <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              dout_q    <= data_q[bit_idx_q + 3'd1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_tick_last) begin
            bit_idx_q <= '0;
            dout_q    <= LINE_IDLE;
            state_q   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (w_tick_last) begin
            if (bit_idx_q == c_STOP_LAST) begin
              done_q    <= 1'b1;
              bit_idx_q <= '0;
              // A queued byte starts its start bit with no idle gap.
              if (!w_empty) begin
                data_q  <= w_head;
                dout_q  <= 1'b0;
                state_q <= S_START;
              end else begin
                dout_q  <= LINE_IDLE;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        default: begin
          dout_q  <= LINE_IDLE;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
